// File: rtl/sel_mux_pkg.sv
// Shared types and defaults for the registered N-channel operand selector.
// Holds the FSM state encoding and a helper that checks the select width.
package sel_mux_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_N  = 9;
  localparam int DEF_SW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // True when an SW-bit select can address all n channels.
  function automatic bit sw_fits(input int sw, input int n);
    return (64'd1 << sw) >= 64'(n);
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Request/response bundle between operand sources, the selector and its consumer.
// The master drives requests and out_ready; the slave is the selector.
interface sel_mux_pipe_if
  import sel_mux_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) ();

  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           req_valid;
  logic           req_ready;
  logic           scan_en;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;
  logic           scan_done;

  modport master (
    output in_data, sel, req_valid, scan_en, out_ready,
    input  req_ready, out_data, out_sel, out_valid, sel_err, scan_done
  );

  modport slave (
    input  in_data, sel, req_valid, scan_en, out_ready,
    output req_ready, out_data, out_sel, out_valid, sel_err, scan_done
  );

endinterface

// File: rtl/sel_mux_scan_ctr.sv
// Channel walker for scan mode: counts 0..N-1 and wraps, with a last-channel flag.
module sel_mux_scan_ctr
  import sel_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [SW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N-channel W-bit selector with valid/ready output slot and a scan
// mode that walks every channel in order for register dump / debug readout.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int SW = DEF_SW
) (
  input logic           clk,
  input logic           rst,
  sel_mux_pipe_if.slave bus
);

  if (!sw_fits(SW, N)) begin : g_param_check
    $error("sel_mux_pipe: SW too narrow for N channels");
  end

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_e        state_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;
  logic          out_valid_q;
  logic          sel_err_q;
  logic          scan_done_q;
  logic          beat_last_q;

  logic          slot_free;
  logic          req_ready;
  logic          req_fire;
  logic          out_fire;
  logic          direct_err;
  logic [SW-1:0] direct_idx;
  logic          scan_load;
  logic          load;
  logic [SW-1:0] ld_idx;
  logic          ld_err;
  logic [W-1:0]  ld_data;
  logic          cnt_clr;
  logic [SW-1:0] cnt;
  logic          cnt_last;

  sel_mux_scan_ctr #(
    .N  (N),
    .SW (SW)
  ) u_scan_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (scan_load),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    slot_free  = !out_valid_q || bus.out_ready;
    req_ready  = slot_free && (state_q == IDLE) && !bus.scan_en;
    req_fire   = bus.req_valid && req_ready;
    out_fire   = out_valid_q && bus.out_ready;
    // Out-of-range selects keep the legacy default-to-last-channel behaviour, now flagged.
    direct_err = (bus.sel > LAST);
    direct_idx = direct_err ? LAST : bus.sel;
    scan_load  = (state_q == SCAN) && bus.scan_en && slot_free;
    load       = req_fire || scan_load;
    ld_idx     = scan_load ? cnt : direct_idx;
    ld_err     = !scan_load && direct_err;
    ld_data    = bus.in_data[int'(ld_idx)*W +: W];
    cnt_clr    = ((state_q == IDLE) && bus.scan_en) || ((state_q == SCAN) && !bus.scan_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      scan_done_q <= 1'b0;
      beat_last_q <= 1'b0;
    end else begin
      scan_done_q <= (state_q == SCAN) && out_fire && beat_last_q;

      unique case (state_q)
        IDLE:    if (bus.scan_en)  state_q <= SCAN;
        SCAN:    if (!bus.scan_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A load and a consume on the same edge keep the slot full: one beat per cycle.
      if (load) begin
        out_data_q  <= ld_data;
        out_sel_q   <= ld_idx;
        sel_err_q   <= ld_err;
        out_valid_q <= 1'b1;
        beat_last_q <= scan_load && cnt_last;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        beat_last_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: table-driven direct selects plus hand-written
// backpressure, scan, scan abort and reset-during-scan sequences.
module tb_sel_mux_pipe;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int SW = 4;

  logic clk;
  logic rst;

  sel_mux_pipe_if #(.W(W), .N(N), .SW(SW)) bus ();

  sel_mux_pipe #(.W(W), .N(N), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] base;
    logic [7:0] exp_data;
    logic [3:0] exp_sel;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] chans(input logic [7:0] base);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = base + 8'(k);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_next;
    bit hit;

    total = 0;
    bad   = 0;

    vecs[0] = '{sel: 4'd3,  base: 8'hA2, exp_data: 8'hA5, exp_sel: 4'd3, exp_err: 1'b0};
    vecs[1] = '{sel: 4'd12, base: 8'h34, exp_data: 8'h3C, exp_sel: 4'd8, exp_err: 1'b1};
    vecs[2] = '{sel: 4'd0,  base: 8'h00, exp_data: 8'h00, exp_sel: 4'd0, exp_err: 1'b0};
    vecs[3] = '{sel: 4'd8,  base: 8'hF0, exp_data: 8'hF8, exp_sel: 4'd8, exp_err: 1'b0};
    vecs[4] = '{sel: 4'd9,  base: 8'h10, exp_data: 8'h18, exp_sel: 4'd8, exp_err: 1'b1};
    vecs[5] = '{sel: 4'd15, base: 8'h20, exp_data: 8'h28, exp_sel: 4'd8, exp_err: 1'b1};
    vecs[6] = '{sel: 4'd5,  base: 8'h5A, exp_data: 8'h5F, exp_sel: 4'd5, exp_err: 1'b0};

    rst           = 1'b1;
    bus.in_data   = '0;
    bus.sel       = '0;
    bus.req_valid = 1'b0;
    bus.scan_en   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_sel_err",   32'(bus.sel_err),   32'd0);
    check("rst_scan_done", 32'(bus.scan_done), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Back-to-back direct requests with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.sel       = vecs[i].sel;
      bus.in_data   = chans(vecs[i].base);
      bus.req_valid = 1'b1;
      #1;
      check("vec_req_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      check("vec_out_valid", 32'(bus.out_valid), 32'd1);
      check("vec_out_data",  32'(bus.out_data),  32'(vecs[i].exp_data));
      check("vec_out_sel",   32'(bus.out_sel),   32'(vecs[i].exp_sel));
      check("vec_sel_err",   32'(bus.sel_err),   32'(vecs[i].exp_err));
    end
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_hold_data", 32'(bus.out_data), 32'h5F);
    check("drain_hold_sel",  32'(bus.out_sel),  32'd5);

    // Backpressure: held beat must ignore later input changes.
    bus.sel = 4'd2; bus.in_data = chans(8'h40); bus.req_valid = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.sel = 4'd6; bus.in_data = chans(8'h80);
    #1;
    check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("bp_data_1",  32'(bus.out_data),  32'h42);
    check("bp_sel_1",   32'(bus.out_sel),   32'd2);
    check("bp_valid_1", 32'(bus.out_valid), 32'd1);
    step();
    check("bp_data_2",  32'(bus.out_data),  32'h42);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    check("bp_new_data", 32'(bus.out_data), 32'h86);
    check("bp_new_sel",  32'(bus.out_sel),  32'd6);
    step();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Full scan with the consumer always ready.
    bus.in_data = chans(8'h10);
    bus.scan_en = 1'b1;
    #1;
    check("scan_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    for (int k = 0; k < N; k++) begin
      step();
      check("scan_sel",   32'(bus.out_sel),   32'(k));
      check("scan_data",  32'(bus.out_data),  32'h10 + 32'(k));
      check("scan_valid", 32'(bus.out_valid), 32'd1);
      check("scan_err",   32'(bus.sel_err),   32'd0);
      check("scan_done_low", 32'(bus.scan_done), 32'd0);
    end
    step();
    check("scan_wrap_sel", 32'(bus.out_sel),   32'd0);
    check("scan_done_hi",  32'(bus.scan_done), 32'd1);
    step();
    check("scan_sel_1",    32'(bus.out_sel),   32'd1);
    check("scan_done_end", 32'(bus.scan_done), 32'd0);

    // Toggling out_ready: every consumed beat must be the next channel; stop at 4.
    exp_next = 1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid && bus.out_sel == 4'd4) begin
        hit = 1'b1;
        break;
      end
      bus.out_ready = i[0];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("toggle_order", 32'(bus.out_sel), 32'(exp_next));
        exp_next++;
      end
      step();
    end
    check("toggle_reached_4", 32'(hit), 32'd1);
    bus.out_ready = 1'b0;
    bus.scan_en   = 1'b0;
    step();
    check("abort_hold_valid", 32'(bus.out_valid), 32'd1);
    check("abort_hold_sel",   32'(bus.out_sel),   32'd4);
    check("abort_hold_data",  32'(bus.out_data),  32'h14);
    check("abort_blocked",    32'(bus.req_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("abort_idle_ready", 32'(bus.req_ready), 32'd1);
    step();
    check("abort_drained", 32'(bus.out_valid), 32'd0);
    check("abort_no_done", 32'(bus.scan_done), 32'd0);

    // Reset in the middle of a scan, then restart from channel 0.
    bus.in_data = chans(8'h30);
    bus.scan_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid && bus.out_sel == 4'd5) begin
        hit = 1'b1;
        break;
      end
    end
    check("rs_reached_5", 32'(hit), 32'd1);
    check("rs_data_5", 32'(bus.out_data), 32'h35);
    rst = 1'b1;
    bus.scan_en = 1'b0;
    step();
    rst = 1'b0;
    check("rs_valid", 32'(bus.out_valid), 32'd0);
    check("rs_sel",   32'(bus.out_sel),   32'd0);
    check("rs_data",  32'(bus.out_data),  32'd0);
    bus.scan_en = 1'b1;
    step();
    step();
    check("rs_restart_sel",  32'(bus.out_sel),  32'd0);
    check("rs_restart_data", 32'(bus.out_data), 32'h30);
    step();
    check("rs_next_sel", 32'(bus.out_sel), 32'd1);
    bus.scan_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

Parametrised, registered N-channel W-bit selector for the processor datapath; successor to the fixed 9×8-bit combinational operand mux. Selects one channel per accepted request into a one-entry output register with valid/ready flow control. Adds a scan mode that walks all channels in order (register dump / debug readout). It sits between the register/operand sources and the ALU or debug port.

## Interface
- W, 8, data width per channel
- N, 9, channel count (2..16)
- SW, 4, select width; must satisfy 2^SW ≥ N
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N*W  flattened channels; channel k at [k*W +: W]
- sel  in  SW  requested channel (direct mode)
- req_valid  in  1  direct-mode request
- req_ready  out  1  request accepted when req_valid & req_ready
- scan_en  in  1  level: enable scan mode
- out_data  out  W  registered selected data
- out_sel  out  SW  channel index that produced out_data
- out_valid  out  1  out_data holds an unconsumed beat
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- sel_err  out  1  current beat came from an out-of-range sel
- scan_done  out  1  one-cycle pulse: last scan beat (channel N-1) consumed

## Operation
- One clock; reset is synchronous and active-high.
- Output slot free when !out_valid | out_ready; req_ready = slot free & state==IDLE & !scan_en.
- States: IDLE, SCAN.
- IDLE: on req_valid & req_ready, load out_data = in_data[sel], out_sel = sel, out_valid = 1, sel_err = 0. If sel ≥ N: load channel N-1, out_sel = N-1, sel_err = 1 (legacy default-to-last behaviour, now flagged).
- IDLE → SCAN when scan_en = 1; counter cnt cleared to 0. Pending direct beat in the output slot is kept and drained normally.
- SCAN: whenever slot free, load in_data[cnt], out_sel = cnt, sel_err = 0, out_valid = 1, cnt increments; at cnt = N-1 wraps to 0.
- scan_done pulses the cycle after the beat with out_sel = N-1 is consumed (out_valid & out_ready & out_sel==N-1 in SCAN).
- scan_en dropped in SCAN: no new beats loaded; held beat stays valid until consumed; return to IDLE the cycle scan_en is sampled low; cnt reset to 0.
- Consume without reload: out_valid → 0 next cycle; out_data/out_sel hold last value.
- in_data sampled only on the load cycle; later input changes do not affect a held beat.

## Timing
- Reset values: out_data 0, out_sel 0, out_valid 0, sel_err 0, scan_done 0, req_ready 1 (after reset, scan_en low), state IDLE, cnt 0.
- Latency: accept at edge t → out_valid high after edge t; data visible same cycle as out_valid.
- Throughput: one beat per cycle with out_ready held high (consume and reload same edge).
- Backpressure: out_ready low with out_valid high → out_data, out_sel, sel_err stable; req_ready 0.
- req_ready is combinational from out_valid, out_ready, state, scan_en; no other comb paths input→output.
- rst asserted mid-scan or mid-hold: all state returns to reset values next edge; held beat discarded.

## Structure
- Package sel_mux_pkg: state enum (IDLE, SCAN), default W/N/SW constants, helper to check 2^SW ≥ N.
- Sub-module sel_mux_scan_ctr: SW-bit counter with clear, enable, wrap at N-1, last flag.
- Channel extract via indexed part-select; out-of-range clamp in parent.

## Test plan
- Reset, then req sel=3 with in ch3=8'hA5, out_ready=1 -> out_valid next cycle, out_data=A5, out_sel=3, sel_err=0.
- sel=12, N=9, ch8=8'h3C -> out_data=3C, out_sel=8, sel_err=1.
- Hold out_ready=0 after beat, change in_data and issue req -> req_ready=0, out_data unchanged; out_ready=1 -> new beat next cycle.
- scan_en=1, out_ready=1, ch k=k+8'h10 -> out_sel 0..8 consecutive cycles, data 10..18, scan_done pulse after ch8, next beat ch0.
- Scan with out_ready toggling 1/0 -> no channel skipped or duplicated; scan_en low at out_sel=4 -> beat 4 drains, IDLE, req_ready=1.
- rst during scan at out_sel=5 -> out_valid=0, out_sel=0, cnt=0 next cycle; scan_en re-asserted restarts at channel 0.
